// File: rtl/mul_rep_ctrl.sv
// Control FSM for the repeated-addition multiplier: captures A and B from a shared
// operand bus, counts B down while strobing product loads. Optional abort: MUL_REP_ABORT_EN.
module mul_rep_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef MUL_REP_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] din,
   output logic             lda,
   output logic             ldp,
   output logic             clrp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_ADD,
      S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      lda        = 1'b0;
      ldp        = 1'b0;
      clrp       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_LOAD_A;
         end
         S_LOAD_A: begin
            lda        = 1'b1;
            state_next = S_LOAD_B;
         end
         S_LOAD_B: begin
            clrp       = 1'b1;
            cnt_next   = din;
            state_next = (din == '0) ? S_DONE : S_ADD;
         end
         S_ADD: begin
            ldp = 1'b1;
            // Guard against zero so the counter can never wrap even if entered oddly.
            cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - WIDTH'(1);
            if (cnt_reg <= WIDTH'(1)) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
`ifdef MUL_REP_ABORT_EN
      // Abort overrides every transition and zeroes the product on the same edge.
      if (abort && state_reg != S_IDLE) begin
         state_next = S_IDLE;
         cnt_next   = '0;
         clrp       = 1'b1;
         done       = 1'b0;
      end
`endif
   end

   assign busy = (state_reg != S_IDLE);
   assign cnt  = cnt_reg;

endmodule

// File: tb/tb_mul_rep_ctrl.sv
// Directed bench for mul_rep_ctrl with a small A/product register model driven by its strobes.
// Define MUL_REP_ABORT_EN to also exercise the abort path.
module tb_mul_rep_ctrl;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
`ifdef MUL_REP_ABORT_EN
   logic             abort;
`endif
   logic [WIDTH-1:0] din;
   logic             lda, ldp, clrp, busy, done;
   logic [WIDTH-1:0] cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0]      lda_v, clrp_v, ldp_v, done_v, busy_v;
   logic [WIDTH-1:0] cnt_c3, cnt_done;
   logic [WIDTH-1:0] a_reg = '0;
   logic [WIDTH-1:0] prod_reg = '0;

   always #5 clk = ~clk;

   mul_rep_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef MUL_REP_ABORT_EN
      .abort (abort),
`endif
      .din   (din),
      .lda   (lda),
      .ldp   (ldp),
      .clrp  (clrp),
      .busy  (busy),
      .done  (done),
      .cnt   (cnt)
   );

   // Datapath registers: clear wins over load, sum wraps at 16 bits.
   always_ff @(posedge clk) begin
      if (lda) a_reg <= din;
      if (clrp)     prod_reg <= '0;
      else if (ldp) prod_reg <= prod_reg + a_reg;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   // Start sampled at edge 0; cycle c is the interval after edge c-1's following edge,
   // sampled 1 time unit after the falling edge. Bit c of each log vector = strobe in cycle c.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit hold, input int repulse_cyc, input int abort_cyc,
                         input int ncyc);
      lda_v = '0; clrp_v = '0; ldp_v = '0; done_v = '0; busy_v = '0;
      cnt_c3 = '0; cnt_done = '1;
      @(negedge clk);
      start = 1'b1;
      din   = '0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = hold || (c == repulse_cyc);
         din   = (c == 1) ? a : (c == 2) ? b : 16'hdead;
`ifdef MUL_REP_ABORT_EN
         abort = (c == abort_cyc);
`else
         if (abort_cyc != 0) $display("[TB] abort requested but feature not built");
`endif
         #1;
         lda_v[c]  = lda;
         clrp_v[c] = clrp;
         ldp_v[c]  = ldp;
         done_v[c] = done;
         busy_v[c] = busy;
         if (c == 3) cnt_c3 = cnt;
         if (done) cnt_done = cnt;
      end
      start = 1'b0;
`ifdef MUL_REP_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
`ifdef MUL_REP_ABORT_EN
      abort = 1'b0;
`endif
      #2;
      chk("reset_strobes", {27'd0, lda, ldp, clrp, busy, done}, 32'h0);
      chk("reset_cnt", 32'(cnt), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // A=5, B=3
      run_op(16'd5, 16'd3, 1'b0, 0, 0, 8);
      chk("t1_lda", lda_v, 32'h2);
      chk("t1_clrp", clrp_v, 32'h4);
      chk("t1_ldp", ldp_v, 32'h38);
      chk("t1_done", done_v, 32'h40);
      chk("t1_busy", busy_v, 32'h7E);
      chk("t1_cnt_c3", 32'(cnt_c3), 32'd3);
      chk("t1_cnt_done", 32'(cnt_done), 32'd0);
      chk("t1_prod", 32'(prod_reg), 32'd15);

      // A=7, B=0
      run_op(16'd7, 16'd0, 1'b0, 0, 0, 6);
      chk("t2_lda", lda_v, 32'h2);
      chk("t2_clrp", clrp_v, 32'h4);
      chk("t2_ldp", ldp_v, 32'h0);
      chk("t2_done", done_v, 32'h8);
      chk("t2_busy", busy_v, 32'hE);
      chk("t2_prod", 32'(prod_reg), 32'd0);

      // A=9, B=1 with start held: IDLE at cycle 5, next LOAD_A at cycle 6
      run_op(16'd9, 16'd1, 1'b1, 0, 0, 6);
      chk("t3_lda", lda_v, 32'h42);
      chk("t3_clrp", clrp_v, 32'h4);
      chk("t3_ldp", ldp_v, 32'h8);
      chk("t3_done", done_v, 32'h10);
      chk("t3_busy", busy_v, 32'h5E);
      chk("t3_prod", 32'(prod_reg), 32'd9);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // A=3, B=4, start re-pulsed during ADD
      run_op(16'd3, 16'd4, 1'b0, 4, 0, 10);
      chk("t4_lda", lda_v, 32'h2);
      chk("t4_clrp", clrp_v, 32'h4);
      chk("t4_ldp", ldp_v, 32'h78);
      chk("t4_done", done_v, 32'h80);
      chk("t4_busy", busy_v, 32'hFE);
      chk("t4_prod", 32'(prod_reg), 32'd12);

      // A=2, B=10: three adds then asynchronous reset mid-cycle
      run_op(16'd2, 16'd10, 1'b0, 0, 0, 5);
      chk("t5_ldp", ldp_v, 32'h38);
      @(negedge clk);
      #1;
      chk("t5_cnt_before", 32'(cnt), 32'd7);
      rst = 1'b1;
      #1;
      chk("t5_rst_strobes", {27'd0, lda, ldp, clrp, busy, done}, 32'h0);
      chk("t5_rst_cnt", 32'(cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("t5_prod_kept", 32'(prod_reg), 32'd6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("t5_idle_busy", {31'd0, busy}, 32'h0);
      end

`ifdef MUL_REP_ABORT_EN
      // A=4, B=6, abort on the second ADD cycle (cycle 4)
      run_op(16'd4, 16'd6, 1'b0, 0, 4, 8);
      chk("t6_clrp", clrp_v, 32'h14);
      chk("t6_ldp", ldp_v, 32'h18);
      chk("t6_done", done_v, 32'h0);
      chk("t6_busy", busy_v, 32'h1E);
      chk("t6_prod", 32'(prod_reg), 32'd0);
      chk("t6_cnt", 32'(cnt), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
